// File: rtl/riscv_ctrl_alu_if.sv
// rtl/riscv_ctrl_alu_if.sv - decode/execute bus between instruction source and riscv_ctrl_alu
interface riscv_ctrl_alu_if #(
  parameter int WIDTH = 32
);
  logic [6:0]       Op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             RegWrite;
  logic             ALUSrc;
  logic             MemWrite;
  logic             ResultSrc;
  logic             branch;
  logic [1:0]       ImmSrc;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic             Z_flag;
  logic             N_flag;
  logic             C_flag;
  logic             V_flag;
  logic [3:0]       flags_q;

  modport master (
    output Op, funct3, funct7, A, B,
    input  RegWrite, ALUSrc, MemWrite, ResultSrc, branch, ImmSrc, ALUControl,
    input  Result, Z_flag, N_flag, C_flag, V_flag, flags_q
  );

  modport slave (
    input  Op, funct3, funct7, A, B,
    output RegWrite, ALUSrc, MemWrite, ResultSrc, branch, ImmSrc, ALUControl,
    output Result, Z_flag, N_flag, C_flag, V_flag, flags_q
  );
endinterface

// File: rtl/riscv_ctrl_alu.sv
// rtl/riscv_ctrl_alu.sv - RV32I single-cycle control decode, ALU and registered flags
module riscv_ctrl_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  riscv_ctrl_alu_if.slave bus
);
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  logic [1:0]       alu_op;
  logic [3:0]       alu_ctrl;
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] result;
  logic             c_flag;
  logic             v_flag;
  logic [3:0]       flags_d;
  logic [3:0]       flags_q;
  logic             unused_ok;

  assign unused_ok = ^{bus.funct7[6], bus.funct7[4:0]};

  always_comb begin
    bus.RegWrite  = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ResultSrc = 1'b0;
    bus.branch    = 1'b0;
    bus.ImmSrc    = 2'b00;
    alu_op        = 2'b00;
    case (bus.Op)
      7'b0000011: begin
        bus.RegWrite  = 1'b1;
        bus.ALUSrc    = 1'b1;
        bus.ResultSrc = 1'b1;
      end
      7'b0100011: begin
        bus.ALUSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.ImmSrc   = 2'b01;
      end
      7'b0110011: begin
        bus.RegWrite = 1'b1;
        alu_op       = 2'b10;
      end
      7'b0010011: begin
        bus.RegWrite = 1'b1;
        bus.ALUSrc   = 1'b1;
        alu_op       = 2'b10;
      end
      7'b1100011: begin
        bus.branch = 1'b1;
        bus.ImmSrc = 2'b10;
        alu_op     = 2'b01;
      end
      default: ;
    endcase
  end

  // I-type ADDI has no SUB form: funct7[5] there is an immediate bit, so Op[5] gates it.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_ctrl = (bus.Op[5] & bus.funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = bus.funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  assign bus.ALUControl = alu_ctrl;

  assign is_sub = (alu_ctrl == ALU_SUB);
  assign b_op   = is_sub ? ~bus.B : bus.B;
  assign sum    = {1'b0, bus.A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  assign shamt  = bus.B[4:0];

  always_comb begin
    result = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (alu_ctrl)
      ALU_ADD, ALU_SUB: begin
        result = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (bus.A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      ALU_AND:  result = bus.A & bus.B;
      ALU_OR:   result = bus.A | bus.B;
      ALU_XOR:  result = bus.A ^ bus.B;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      ALU_SLL:  result = bus.A << shamt;
      ALU_SRL:  result = bus.A >> shamt;
      ALU_SRA:  result = $unsigned($signed(bus.A) >>> shamt);
      default:  result = '0;
    endcase
  end

  assign bus.Result = result;
  assign bus.Z_flag = (result == '0);
  assign bus.N_flag = result[WIDTH-1];
  assign bus.C_flag = c_flag;
  assign bus.V_flag = v_flag;

  assign flags_d = {bus.Z_flag, bus.N_flag, c_flag, v_flag};

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags_q = flags_q;
endmodule

// File: tb/tb_riscv_ctrl_alu.sv
// tb/tb_riscv_ctrl_alu.sv - scoreboard bench for riscv_ctrl_alu
module tb_riscv_ctrl_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stim_valid = 1'b0;

  always #5 clk = ~clk;

  riscv_ctrl_alu_if #(.WIDTH(32)) bus ();

  riscv_ctrl_alu #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [6:0] ctrl;
    logic [3:0] alu;
    logic [31:0] res;
    logic [3:0] flags;
    logic [3:0] fq;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] model_fq = 4'b0000;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, id, act, exp);
    end
  endtask

  // Monitor: compares whatever the stimulus announced, mid-cycle.
  always @(negedge clk) begin
    if (stim_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ctrl", e.id, {25'd0, bus.RegWrite, bus.ALUSrc, bus.MemWrite, bus.ResultSrc,
                              bus.branch, bus.ImmSrc}, {25'd0, e.ctrl});
        check("alu_ctrl", e.id, {28'd0, bus.ALUControl}, {28'd0, e.alu});
        check("result", e.id, bus.Result, e.res);
        check("flags", e.id, {28'd0, bus.Z_flag, bus.N_flag, bus.C_flag, bus.V_flag}, {28'd0, e.flags});
        check("flags_q", e.id, {28'd0, bus.flags_q}, {28'd0, e.fq});
      end
    end
  end

  task automatic apply(input int id, input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] ctrl, input logic [3:0] alu, input logic [31:0] res,
                       input logic [3:0] flags);
    exp_t e;
    rst        = r;
    bus.Op     = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.A      = a;
    bus.B      = b;
    e.id = id; e.ctrl = ctrl; e.alu = alu; e.res = res; e.flags = flags; e.fq = model_fq;
    exp_q.push_back(e);
    stim_valid = 1'b1;
    @(posedge clk);
    model_fq = r ? 4'b0000 : flags;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ctrl = {RegWrite, ALUSrc, MemWrite, ResultSrc, branch, ImmSrc}; flags = {Z,N,C,V}
  initial begin
    bus.Op = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.A = 32'd0; bus.B = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply( 1, 0, 7'b0110011, 3'b000, 7'b0000000, 32'd15, 32'd10, 7'b1000000, 4'b0000, 32'd25, 4'b0000);
    apply( 2, 0, 7'b0110011, 3'b000, 7'b0100000, 32'd20, 32'd5, 7'b1000000, 4'b0001, 32'd15, 4'b0010);
    apply( 3, 0, 7'b1100011, 3'b000, 7'b0000000, 32'd40, 32'd40, 7'b0000110, 4'b0001, 32'd0, 4'b1010);
    apply( 4, 0, 7'b0000011, 3'b010, 7'b0000000, 32'd100, 32'd8, 7'b1101000, 4'b0000, 32'd108, 4'b0000);
    apply( 5, 0, 7'b0100011, 3'b010, 7'b0000000, 32'd200, 32'd16, 7'b0110001, 4'b0000, 32'd216, 4'b0000);
    apply( 6, 0, 7'b0110011, 3'b000, 7'b0000000, 32'h7FFFFFFF, 32'd1, 7'b1000000, 4'b0000, 32'h80000000, 4'b0101);
    apply( 7, 0, 7'b0110011, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 7'b1000000, 4'b1001, 32'hF8000000, 4'b0100);
    apply( 8, 1, 7'b0110011, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd0, 7'b1000000, 4'b0100, 32'hFFFFFFFF, 4'b0100);
    apply( 9, 0, 7'b1111111, 3'b000, 7'b0000000, 32'd5, 32'd3, 7'b0000000, 4'b0000, 32'd8, 4'b0000);
    apply(10, 0, 7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd10, 7'b1000000, 4'b0001, 32'hFFFFFFFB, 4'b0100);
    apply(11, 0, 7'b0010011, 3'b000, 7'b0100000, 32'd7, 32'd3, 7'b1100000, 4'b0000, 32'd10, 4'b0000);
    apply(12, 0, 7'b0110011, 3'b011, 7'b0000000, 32'd1, 32'hFFFFFFFF, 7'b1000000, 4'b0110, 32'd1, 4'b0000);
    apply(13, 0, 7'b0110011, 3'b001, 7'b0000000, 32'd1, 32'h25, 7'b1000000, 4'b0111, 32'h20, 4'b0000);
    apply(14, 0, 7'b0110011, 3'b101, 7'b0000000, 32'h80000000, 32'd31, 7'b1000000, 4'b1000, 32'd1, 4'b0000);
    apply(15, 0, 7'b0110011, 3'b110, 7'b0000000, 32'd0, 32'd0, 7'b1000000, 4'b0011, 32'd0, 4'b1000);
    apply(16, 0, 7'b0110011, 3'b000, 7'b0100000, 32'h80000000, 32'd1, 7'b1000000, 4'b0001, 32'h7FFFFFFF, 4'b0011);
    apply(17, 0, 7'b0110011, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 7'b1000000, 4'b0101, 32'd1, 4'b0000);
    apply(18, 0, 7'b0010011, 3'b111, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 7'b1100000, 4'b0010, 32'h0000F000, 4'b0000);
    stim_valid = 1'b0;
    @(posedge clk);
    #1;
    check("queue_drained", 0, exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
